// File: rtl/kch_sequencer_if.sv
// Signal bundle between a heartbeat/advert source, kch_sequencer and knownCHv2.
// The master drives round control and parsed packet fields; the slave drives the knownCHv2 side and status.
interface kch_sequencer_if #(
  parameter int WORD_WIDTH = 16,
  parameter int MAX_CH     = 8
);
  localparam int CW = $clog2(MAX_CH + 1);

  logic                  start;
  logic                  hb_valid;
  logic [WORD_WIDTH-1:0] hb_chlimit;
  logic                  pkt_valid;
  logic                  pkt_ready;
  logic [WORD_WIDTH-1:0] pkt_ch_id;
  logic [WORD_WIDTH-1:0] pkt_hops;
  logic [WORD_WIDTH-1:0] pkt_qvalue;
  logic                  HB_reset;
  logic [WORD_WIDTH-1:0] HB_CHlimit;
  logic                  en_KCH;
  logic [WORD_WIDTH-1:0] fCH_ID;
  logic [WORD_WIDTH-1:0] fCH_Hops;
  logic [WORD_WIDTH-1:0] fCH_QValue;
  logic [CW-1:0]         ch_count;
  logic                  drop;
  logic                  busy;
  logic                  done;
  logic                  timeout;

  modport master (
    output start, hb_valid, hb_chlimit, pkt_valid, pkt_ch_id, pkt_hops, pkt_qvalue,
    input  pkt_ready, HB_reset, HB_CHlimit, en_KCH, fCH_ID, fCH_Hops, fCH_QValue,
    input  ch_count, drop, busy, done, timeout
  );

  modport slave (
    input  start, hb_valid, hb_chlimit, pkt_valid, pkt_ch_id, pkt_hops, pkt_qvalue,
    output pkt_ready, HB_reset, HB_CHlimit, en_KCH, fCH_ID, fCH_Hops, fCH_QValue,
    output ch_count, drop, busy, done, timeout
  );
endinterface

// File: rtl/kch_sequencer.sv
// Per-round knownCHv2 controller: filters invalid/duplicate CH adverts and issues each new CH once.
// Advert accepted at edge N appears on fCH_* with en_KCH in cycle N+1; pkt_ready drops outside COLLECT.
module kch_sequencer #(
  parameter int WORD_WIDTH = 16,
  parameter int MAX_CH     = 8,
  parameter int TIMEOUT    = 1000
) (
  input logic            clk,
  input logic            nrst,
  kch_sequencer_if.slave bus
);
  localparam int CW = $clog2(MAX_CH + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [WORD_WIDTH-1:0] MAX_L = WORD_WIDTH'(MAX_CH);

  typedef enum logic [2:0] {S_IDLE, S_WAIT_HB, S_COLLECT, S_ISSUE, S_DONE} state_e;

  state_e                state_q, state_d;
  logic [WORD_WIDTH-1:0] limit_q, limit_d;
  logic                  hbr_q, hbr_d;
  logic                  en_q, en_d;
  logic                  drop_q, drop_d;
  logic                  done_q, done_d;
  logic                  timeout_q, timeout_d;
  logic [WORD_WIDTH-1:0] fid_q, fid_d;
  logic [WORD_WIDTH-1:0] fhops_q, fhops_d;
  logic [WORD_WIDTH-1:0] fq_q, fq_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic [WORD_WIDTH-1:0] tbl_id_q [MAX_CH];
  logic [WORD_WIDTH-1:0] tbl_id_d [MAX_CH];
  logic [MAX_CH-1:0]     tbl_vld_q, tbl_vld_d;

  logic                  id_hit;
  logic                  tmr_exp;
  logic [CW-1:0]         cnt_inc;
  logic [WORD_WIDTH-1:0] lim_clamp;

  assign tmr_exp   = (timer_q >= TW'(TIMEOUT - 1));
  assign cnt_inc   = cnt_q + CW'(1);
  assign lim_clamp = (bus.hb_chlimit > MAX_L) ? MAX_L : bus.hb_chlimit;

  always_comb begin
    id_hit = 1'b0;
    for (int i = 0; i < MAX_CH; i++) begin
      if (tbl_vld_q[i] && (tbl_id_q[i] == bus.pkt_ch_id)) id_hit = 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    limit_d   = limit_q;
    hbr_d     = 1'b0;
    en_d      = 1'b0;
    drop_d    = 1'b0;
    done_d    = 1'b0;
    timeout_d = timeout_q;
    fid_d     = fid_q;
    fhops_d   = fhops_q;
    fq_d      = fq_q;
    cnt_d     = cnt_q;
    timer_d   = timer_q;
    tbl_id_d  = tbl_id_q;
    tbl_vld_d = tbl_vld_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d   = S_WAIT_HB;
          tbl_vld_d = '0;
          cnt_d     = '0;
          timeout_d = 1'b0;
        end
      end
      S_WAIT_HB, S_COLLECT: begin
        // A heartbeat (first or repeated) always (re)opens the round and blocks adverts that cycle.
        if (bus.hb_valid) begin
          limit_d   = lim_clamp;
          hbr_d     = 1'b1;
          timer_d   = '0;
          tbl_vld_d = '0;
          cnt_d     = '0;
          if (lim_clamp == '0) begin
            state_d   = S_DONE;
            done_d    = 1'b1;
            timeout_d = 1'b0;
          end else begin
            state_d = S_COLLECT;
          end
        end else if (state_q == S_COLLECT) begin
          timer_d = timer_q + TW'(1);
          if (bus.pkt_valid && (bus.pkt_hops != '1) && !id_hit) begin
            fid_d   = bus.pkt_ch_id;
            fhops_d = bus.pkt_hops;
            fq_d    = bus.pkt_qvalue;
            en_d    = 1'b1;
            state_d = S_ISSUE;
          end else begin
            drop_d = bus.pkt_valid;
            if (tmr_exp) begin
              state_d   = S_DONE;
              done_d    = 1'b1;
              timeout_d = 1'b1;
            end
          end
        end
      end
      S_ISSUE: begin
        timer_d = timer_q + TW'(1);
        cnt_d   = cnt_inc;
        for (int i = 0; i < MAX_CH; i++) begin
          if (CW'(i) == cnt_q) begin
            tbl_id_d[i]  = fid_q;
            tbl_vld_d[i] = 1'b1;
          end
        end
        // Reaching the limit wins over a simultaneous timer expiry.
        if (WORD_WIDTH'(cnt_inc) == limit_q) begin
          state_d   = S_DONE;
          done_d    = 1'b1;
          timeout_d = 1'b0;
        end else if (tmr_exp) begin
          state_d   = S_DONE;
          done_d    = 1'b1;
          timeout_d = 1'b1;
        end else begin
          state_d = S_COLLECT;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q   <= S_IDLE;
      limit_q   <= '0;
      hbr_q     <= 1'b0;
      en_q      <= 1'b0;
      drop_q    <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      fid_q     <= '0;
      fhops_q   <= '1;
      fq_q      <= '0;
      cnt_q     <= '0;
      timer_q   <= '0;
      tbl_vld_q <= '0;
    end else begin
      state_q   <= state_d;
      limit_q   <= limit_d;
      hbr_q     <= hbr_d;
      en_q      <= en_d;
      drop_q    <= drop_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
      fid_q     <= fid_d;
      fhops_q   <= fhops_d;
      fq_q      <= fq_d;
      cnt_q     <= cnt_d;
      timer_q   <= timer_d;
      tbl_vld_q <= tbl_vld_d;
    end
  end

  always_ff @(posedge clk) begin
    tbl_id_q <= tbl_id_d;
  end

  assign bus.pkt_ready  = (state_q == S_COLLECT) && !bus.hb_valid;
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.HB_reset   = hbr_q;
  assign bus.HB_CHlimit = limit_q;
  assign bus.en_KCH     = en_q;
  assign bus.fCH_ID     = fid_q;
  assign bus.fCH_Hops   = fhops_q;
  assign bus.fCH_QValue = fq_q;
  assign bus.ch_count   = cnt_q;
  assign bus.drop       = drop_q;
  assign bus.done       = done_q;
  assign bus.timeout    = timeout_q;
endmodule

// File: tb/tb_kch_sequencer.sv
// Bench for kch_sequencer: directed vector table, corner-case sequences, then random traffic against a round-level model.
module tb_kch_sequencer;
  localparam int W    = 16;
  localparam int MAXC = 8;
  localparam int TO   = 40;
  localparam int CW   = $clog2(MAXC + 1);

  logic clk  = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  kch_sequencer_if #(.WORD_WIDTH(W), .MAX_CH(MAXC)) bus ();
  kch_sequencer #(.WORD_WIDTH(W), .MAX_CH(MAXC), .TIMEOUT(TO)) dut (
    .clk(clk), .nrst(nrst), .bus(bus)
  );

  int    checks = 0;
  int    errors = 0;
  string tag    = "init";
  bit    last_rdy;

  // Round-level reference: round open flags, seen-ID list, cycles elapsed since the heartbeat.
  bit           m_round, m_hb, m_iss, m_close;
  int           m_cyc, m_lim, m_cnt;
  logic [W-1:0] m_seen[$];
  bit           e_hbr, e_en, e_drop, e_done, e_to;
  logic [W-1:0] e_fid, e_fh, e_fq;

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_round = 0; m_hb = 0; m_iss = 0; m_close = 0;
    m_cyc = 0; m_lim = 0; m_cnt = 0; m_seen.delete();
    e_hbr = 0; e_en = 0; e_drop = 0; e_done = 0; e_to = 0;
    e_fid = '0; e_fh = '1; e_fq = '0;
  endfunction

  function automatic bit seen_has(logic [W-1:0] id);
    foreach (m_seen[i]) if (m_seen[i] == id) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void finish_round(bit to);
    m_close = 1; e_done = 1; e_to = to;
  endfunction

  function automatic void model_edge();
    e_hbr = 0; e_en = 0; e_drop = 0; e_done = 0;
    if (!nrst) begin
      model_reset();
    end else if (!m_round) begin
      if (bus.start) begin
        m_round = 1; m_hb = 0; m_seen.delete(); m_cnt = 0; e_to = 0;
      end
    end else if (m_close) begin
      m_round = 0; m_close = 0;
    end else if (!m_hb || (!m_iss && bus.hb_valid)) begin
      if (bus.hb_valid) begin
        m_lim = (int'(bus.hb_chlimit) > MAXC) ? MAXC : int'(bus.hb_chlimit);
        e_hbr = 1; m_cyc = 0; m_seen.delete(); m_cnt = 0; m_hb = 1;
        if (m_lim == 0) finish_round(0);
      end
    end else if (m_iss) begin
      m_iss = 0; m_cnt++; m_cyc++;
      if (m_cnt == m_lim) finish_round(0);
      else if (m_cyc >= TO) finish_round(1);
    end else begin
      m_cyc++;
      if (bus.pkt_valid && bus.pkt_hops != '1 && !seen_has(bus.pkt_ch_id)) begin
        m_seen.push_back(bus.pkt_ch_id);
        e_fid = bus.pkt_ch_id; e_fh = bus.pkt_hops; e_fq = bus.pkt_qvalue;
        e_en = 1; m_iss = 1;
      end else begin
        e_drop = bus.pkt_valid;
        if (m_cyc >= TO) finish_round(1);
      end
    end
  endfunction

  function automatic logic [127:0] act_regs();
    return 128'({bus.HB_reset, bus.en_KCH, bus.drop, bus.done, bus.timeout, bus.ch_count,
                 bus.HB_CHlimit, bus.fCH_ID, bus.fCH_Hops, bus.fCH_QValue});
  endfunction

  function automatic logic [127:0] exp_regs();
    return 128'({e_hbr, e_en, e_drop, e_done, e_to, CW'(m_cnt), W'(m_lim), e_fid, e_fh, e_fq});
  endfunction

  task automatic step(bit st, bit hb, int lim, bit pv, int id, int hops, int q);
    bit exp_rdy;
    bus.start = st; bus.hb_valid = hb; bus.hb_chlimit = W'(lim);
    bus.pkt_valid = pv; bus.pkt_ch_id = W'(id); bus.pkt_hops = W'(hops); bus.pkt_qvalue = W'(q);
    #1;
    last_rdy = bus.pkt_ready;
    exp_rdy  = m_round && m_hb && !m_close && !m_iss && !hb;
    chk({tag, "/rdy_busy"}, {bus.pkt_ready, bus.busy}, {exp_rdy, m_round});
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk({tag, "/regs"}, act_regs(), exp_regs());
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0);
  endtask

  typedef struct {
    bit st; bit hb; int lim; bit pv; int id; int hops; int q;
    bit x_rdy; bit x_hbr; bit x_en; bit x_drop; bit x_done; bit x_to; int x_fid; int x_cnt;
  } vec_t;

  vec_t tv[17];

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation did not complete, got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    int n;
    bit saw;
    int dens;

    //              st hb lim pv id  hops     q        rdy hbr en dr dn to fid cnt
    tv[0]  = '{1, 0, 0, 0, 0,  0,       0,       0, 0, 0, 0, 0, 0, 0,  0};
    tv[1]  = '{0, 1, 3, 0, 0,  0,       0,       0, 1, 0, 0, 0, 0, 0,  0};
    tv[2]  = '{0, 0, 0, 1, 23, 2,       'h3000,  1, 0, 1, 0, 0, 0, 23, 0};
    tv[3]  = '{0, 0, 0, 0, 0,  0,       0,       0, 0, 0, 0, 0, 0, 23, 1};
    tv[4]  = '{0, 0, 0, 1, 7,  1,       'h2000,  1, 0, 1, 0, 0, 0, 7,  1};
    tv[5]  = '{0, 0, 0, 0, 0,  0,       0,       0, 0, 0, 0, 0, 0, 7,  2};
    tv[6]  = '{0, 0, 0, 1, 41, 3,       'h1000,  1, 0, 1, 0, 0, 0, 41, 2};
    tv[7]  = '{0, 0, 0, 0, 0,  0,       0,       0, 0, 0, 0, 1, 0, 41, 3};
    tv[8]  = '{0, 0, 0, 0, 0,  0,       0,       0, 0, 0, 0, 0, 0, 41, 3};
    tv[9]  = '{1, 0, 0, 0, 0,  0,       0,       0, 0, 0, 0, 0, 0, 41, 0};
    tv[10] = '{0, 1, 3, 0, 0,  0,       0,       0, 1, 0, 0, 0, 0, 41, 0};
    tv[11] = '{0, 0, 0, 1, 23, 2,       'h3000,  1, 0, 1, 0, 0, 0, 23, 0};
    tv[12] = '{0, 0, 0, 0, 0,  0,       0,       0, 0, 0, 0, 0, 0, 23, 1};
    tv[13] = '{0, 0, 0, 1, 23, 2,       'h3000,  1, 0, 0, 1, 0, 0, 23, 1};
    tv[14] = '{0, 0, 0, 1, 9,  1,       'h1111,  1, 0, 1, 0, 0, 0, 9,  1};
    tv[15] = '{0, 0, 0, 0, 0,  0,       0,       0, 0, 0, 0, 0, 0, 9,  2};
    tv[16] = '{0, 0, 0, 1, 5,  'hFFFF,  'h0500,  1, 0, 0, 1, 0, 0, 9,  2};

    bus.start = 0; bus.hb_valid = 0; bus.hb_chlimit = '0; bus.pkt_valid = 0;
    bus.pkt_ch_id = '0; bus.pkt_hops = '0; bus.pkt_qvalue = '0;
    model_reset();

    nrst = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    nrst = 1;
    tag = "reset";
    chk("reset/regs", act_regs(), 128'({5'b0, CW'(0), W'(0), W'(0), 16'hFFFF, W'(0)}));
    chk("reset/rdy_busy", {bus.pkt_ready, bus.busy}, 2'b00);

    tag = "table";
    for (int i = 0; i < 17; i++) begin
      step(tv[i].st, tv[i].hb, tv[i].lim, tv[i].pv, tv[i].id, tv[i].hops, tv[i].q);
      chk($sformatf("tv%0d", i),
          {last_rdy, bus.HB_reset, bus.en_KCH, bus.drop, bus.done, bus.timeout, bus.fCH_ID, bus.ch_count},
          {tv[i].x_rdy, tv[i].x_hbr, tv[i].x_en, tv[i].x_drop, tv[i].x_done, tv[i].x_to,
           W'(tv[i].x_fid), CW'(tv[i].x_cnt)});
    end

    tag = "t2_timer";
    n = 0;
    do begin idle(); n++; end while (!bus.done && n < 60);
    chk("t2_done_cycle", n, 34);
    chk("t2_timeout", {bus.done, bus.timeout, bus.ch_count}, {2'b11, CW'(2)});
    idle();
    chk("t2_timeout_held", bus.timeout, 1);

    tag = "t3_clamp";
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 20, 0, 0, 0, 0);
    chk("t3_limit", bus.HB_CHlimit, 8);
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 0, 1, 100 + i, 1, i);
      chk($sformatf("t3_en%0d", i), {bus.en_KCH, bus.fCH_ID}, {1'b1, W'(100 + i)});
      idle();
    end
    chk("t3_done", {bus.done, bus.timeout, bus.ch_count}, {2'b10, CW'(8)});
    idle();
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    chk("t3_zero_limit", {bus.HB_reset, bus.done, bus.en_KCH, bus.timeout, bus.ch_count},
        {4'b1100, CW'(0)});
    idle();

    tag = "t4_restart";
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 3, 0, 0, 0, 0);
    step(0, 0, 0, 1, 23, 2, 'h3000); idle();
    step(0, 0, 0, 1, 24, 2, 'h3001); idle();
    chk("t4_cnt2", bus.ch_count, 2);
    step(0, 1, 2, 1, 30, 1, 1);
    chk("t4_restart", {last_rdy, bus.HB_reset, bus.en_KCH, bus.ch_count, bus.HB_CHlimit},
        {3'b010, CW'(0), W'(2)});
    step(0, 0, 0, 1, 23, 4, 'h0404);
    chk("t4_reaccept", {bus.en_KCH, bus.fCH_ID, bus.fCH_Hops}, {1'b1, W'(23), W'(4)});
    idle();
    step(0, 0, 0, 1, 31, 1, 0); idle();
    chk("t4_done", {bus.done, bus.ch_count}, {1'b1, CW'(2)});
    idle();

    tag = "t5_issue_expiry";
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 3, 0, 0, 0, 0);
    repeat (TO - 2) idle();
    step(0, 0, 0, 1, 50, 2, 'h5050);
    chk("t5_en", {bus.en_KCH, bus.fCH_ID}, {1'b1, W'(50)});
    idle();
    chk("t5_done_to", {bus.done, bus.timeout, bus.ch_count}, {2'b11, CW'(1)});
    idle();
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0, 0);
    repeat (TO - 2) idle();
    step(0, 0, 0, 1, 51, 2, 'h5151);
    idle();
    chk("t5_done_limit", {bus.done, bus.timeout, bus.ch_count}, {2'b10, CW'(1)});
    idle();

    tag = "t6_reset";
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 3, 0, 0, 0, 0);
    step(0, 0, 0, 1, 60, 2, 7); idle();
    step(0, 0, 0, 1, 61, 3, 8); idle();
    chk("t6_cnt2", bus.ch_count, 2);
    nrst = 0;
    idle();
    nrst = 1;
    chk("t6_reset_regs", act_regs(), 128'({5'b0, CW'(0), W'(0), W'(0), 16'hFFFF, W'(0)}));
    chk("t6_reset_busy", bus.busy, 0);
    saw = 0;
    for (int i = 0; i < 5; i++) begin idle(); saw |= bus.done; end
    chk("t6_no_done", saw, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    chk("t6_restart", bus.busy, 1);

    tag = "rand";
    dens = 50;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) dens = (($urandom % 3) == 0) ? 5 : ((($urandom % 2) == 0) ? 50 : 90);
      nrst = ($urandom % 400) != 0;
      step(($urandom % 8) == 0, ($urandom % 24) == 0, int'($urandom % 11),
           int'($urandom % 100) < dens, int'($urandom % 12),
           (($urandom % 8) == 0) ? 'hFFFF : int'($urandom % 5), int'($urandom % 65536));
    end
    nrst = 1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
